// File: rtl/ct_idu_rf_lwb_arb_if.sv
// Late-writeback bus: requester handshake, pipe1 slot status and the registered
// writeback beat / issue-stall outputs of ct_idu_rf_lwb_arb.
interface ct_idu_rf_lwb_arb_if #(
  parameter int REQ_NUM = 3
);
  logic [REQ_NUM-1:0]    x_req_vld;
  logic [7*REQ_NUM-1:0]  x_req_preg;
  logic [64*REQ_NUM-1:0] x_req_data;
  logic [REQ_NUM-1:0]    x_req_grant;
  logic                  iu_idu_ex1_pipe1_wb_vld;
  logic                  lwb_idu_wb_preg_vld;
  logic [6:0]            lwb_idu_wb_preg;
  logic [63:0]           lwb_idu_wb_preg_data;
  logic                  lwb_idu_pipe1_issue_stall;

  modport master (
    output x_req_vld, x_req_preg, x_req_data, iu_idu_ex1_pipe1_wb_vld,
    input  x_req_grant, lwb_idu_wb_preg_vld, lwb_idu_wb_preg,
           lwb_idu_wb_preg_data, lwb_idu_pipe1_issue_stall
  );

  modport slave (
    input  x_req_vld, x_req_preg, x_req_data, iu_idu_ex1_pipe1_wb_vld,
    output x_req_grant, lwb_idu_wb_preg_vld, lwb_idu_wb_preg,
           lwb_idu_wb_preg_data, lwb_idu_pipe1_issue_stall
  );
endinterface

// File: rtl/ct_idu_rf_lwb_arb.sv
// Round-robin arbiter for the shared pipe1 late-writeback slot with a registered beat.
// Optional starvation stall enabled by defining CT_IDU_LWB_STARVE_STALL_EN.
module ct_idu_rf_lwb_arb #(
  parameter int REQ_NUM      = 3,
  parameter int STARVE_LIMIT = 8
) (
  input logic                 forever_cpuclk,
  input logic                 cpurst,
  ct_idu_rf_lwb_arb_if.slave  lwb
);
  localparam int PREG_W = 7;
  localparam int DATA_W = 64;
  localparam int PTR_W  = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

  logic [PTR_W-1:0]  rr_ptr;
  logic [REQ_NUM-1:0] grant;
  logic [PTR_W-1:0]  grant_idx;
  logic              grant_any;
  logic              eligible;
  logic [PREG_W-1:0] sel_preg;
  logic [DATA_W-1:0] sel_data;
  int                scan_idx;

  logic              beat_vld_p1;
  logic [PREG_W-1:0] beat_preg_p1;
  logic [DATA_W-1:0] beat_data_p1;

  // Stage 0: combinational grant, searching from rr_ptr upward with wrap
  assign eligible = !cpurst && !lwb.iu_idu_ex1_pipe1_wb_vld;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    scan_idx  = 0;
    if (eligible) begin
      for (int k = 0; k < REQ_NUM; k++) begin
        scan_idx = (int'(rr_ptr) + k) % REQ_NUM;
        if (!grant_any && lwb.x_req_vld[scan_idx]) begin
          grant_any        = 1'b1;
          grant[scan_idx]  = 1'b1;
          grant_idx        = PTR_W'(scan_idx);
        end
      end
    end
  end

  always_comb begin
    sel_preg = '0;
    sel_data = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (grant[i]) begin
        sel_preg = sel_preg | lwb.x_req_preg[PREG_W*i +: PREG_W];
        sel_data = sel_data | lwb.x_req_data[DATA_W*i +: DATA_W];
      end
    end
  end

  assign lwb.x_req_grant = grant;

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst)
      rr_ptr <= '0;
    else if (grant_any)
      rr_ptr <= (grant_idx == PTR_W'(REQ_NUM - 1)) ? '0 : grant_idx + PTR_W'(1);
  end

  // Stage 1: registered writeback beat
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      beat_vld_p1  <= 1'b0;
      beat_preg_p1 <= '0;
      beat_data_p1 <= '0;
    end else begin
      beat_vld_p1 <= grant_any;
      if (grant_any) begin
        beat_preg_p1 <= sel_preg;
        beat_data_p1 <= sel_data;
      end
    end
  end

  assign lwb.lwb_idu_wb_preg_vld  = beat_vld_p1;
  assign lwb.lwb_idu_wb_preg      = beat_preg_p1;
  assign lwb.lwb_idu_wb_preg_data = beat_data_p1;

`ifdef CT_IDU_LWB_STARVE_STALL_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;
  logic [3:0] starve_cnt_nxt;
  logic       stall_p1;

  // A grant and an increment are mutually exclusive, so grant wins the clear
  always_comb begin
    starve_cnt_nxt = starve_cnt;
    if (grant_any || !(|lwb.x_req_vld))
      starve_cnt_nxt = '0;
    else if (starve_cnt < LIMIT)
      starve_cnt_nxt = starve_cnt + 4'd1;
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      starve_cnt <= '0;
      stall_p1   <= 1'b0;
    end else begin
      starve_cnt <= starve_cnt_nxt;
      stall_p1   <= (starve_cnt_nxt >= LIMIT);
    end
  end

  assign lwb.lwb_idu_pipe1_issue_stall = stall_p1;
`else
  assign lwb.lwb_idu_pipe1_issue_stall = 1'b0;
`endif
endmodule

// File: tb/tb_ct_idu_rf_lwb_arb.sv
// Randomized bench for ct_idu_rf_lwb_arb against a queue-free behavioural model.
module tb_ct_idu_rf_lwb_arb;
  localparam int N     = 3;
  localparam int LIMIT = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ct_idu_rf_lwb_arb_if #(.REQ_NUM(N)) bus ();
  ct_idu_rf_lwb_arb #(.REQ_NUM(N), .STARVE_LIMIT(LIMIT)) dut (
    .forever_cpuclk (clk),
    .cpurst         (rst),
    .lwb            (bus)
  );

  int total = 0;
  int bad   = 0;

  // requester-side stimulus state
  logic        vld  [N];
  logic [6:0]  preg [N];
  logic [63:0] data [N];
  logic        busy;

  // behavioural model of visible state
  int          m_ptr, m_cnt;
  logic        m_stall, m_bvld;
  logic [6:0]  m_bpreg;
  logic [63:0] m_bdata;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive at negedge, check settled outputs, advance model, step clock
  task automatic cycle();
    int g, best, d;
    bit any;
    logic [N-1:0] exp_g;
    for (int i = 0; i < N; i++) begin
      bus.x_req_vld[i]         = vld[i];
      bus.x_req_preg[7*i +: 7]   = preg[i];
      bus.x_req_data[64*i +: 64] = data[i];
    end
    bus.iu_idu_ex1_pipe1_wb_vld = busy;
    #1;
    g = -1; best = N; any = 0;
    for (int i = 0; i < N; i++) begin
      any |= vld[i];
      d = (i - m_ptr + N) % N;
      if (!rst && !busy && vld[i] && d < best) begin
        best = d;
        g    = i;
      end
    end
    exp_g = '0;
    if (g >= 0) exp_g[g] = 1'b1;
    check("grant", 64'(bus.x_req_grant), 64'(exp_g));
    check("wb_vld", 64'(bus.lwb_idu_wb_preg_vld), 64'(m_bvld));
    check("wb_preg", 64'(bus.lwb_idu_wb_preg), 64'(m_bpreg));
    check("wb_data", bus.lwb_idu_wb_preg_data, m_bdata);
`ifdef CT_IDU_LWB_STARVE_STALL_EN
    check("stall", 64'(bus.lwb_idu_pipe1_issue_stall), 64'(m_stall));
`else
    check("stall", 64'(bus.lwb_idu_pipe1_issue_stall), 64'd0);
`endif
    if (rst) begin
      m_ptr = 0; m_cnt = 0; m_stall = 0; m_bvld = 0; m_bpreg = '0; m_bdata = '0;
    end else begin
      m_bvld = (g >= 0);
      if (g >= 0) begin
        m_bpreg = preg[g];
        m_bdata = data[g];
        m_ptr   = (g + 1) % N;
        m_cnt   = 0;
      end else if (!any) begin
        m_cnt = 0;
      end else if (m_cnt < LIMIT) begin
        m_cnt++;
      end
      m_stall = (m_cnt >= LIMIT);
    end
    if (g >= 0) vld[g] = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) begin
      vld[i] = 1'b0; preg[i] = '0; data[i] = '0;
    end
  endtask

  task automatic do_reset();
    clear_reqs();
    busy = 1'b0;
    rst  = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  int burst;

  initial begin
    clear_reqs();
    busy = 1'b0;
    rst  = 1'b1;
    for (int i = 0; i < N; i++) begin
      bus.x_req_vld[i] = 1'b0;
    end
    bus.x_req_preg = '0;
    bus.x_req_data = '0;
    bus.iu_idu_ex1_pipe1_wb_vld = 1'b0;
    @(posedge clk);
    @(negedge clk);
    m_ptr = 0; m_cnt = 0; m_stall = 0; m_bvld = 0; m_bpreg = '0; m_bdata = '0;

    // reset held with every requester asserting: no grant may appear
    for (int i = 0; i < N; i++) begin
      vld[i] = 1'b1; preg[i] = 7'(i + 1); data[i] = 64'(i + 100);
    end
    cycle();
    cycle();
    rst = 1'b0;
    clear_reqs();
    cycle();

    // single request
    do_reset();
    vld[0] = 1'b1; preg[0] = 7'h15; data[0] = 64'hDEAD_BEEF;
    cycle();
    cycle();
    cycle();

    // round robin with all requesters permanently asking
    do_reset();
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!vld[i]) begin
          vld[i] = 1'b1; preg[i] = 7'(16 * c + i); data[i] = 64'(1000 * c + i);
        end
      end
      cycle();
    end
    clear_reqs();
    cycle();

    // busy slot for three cycles
    do_reset();
    vld[1] = 1'b1; preg[1] = 7'h2A; data[1] = 64'h1111_2222_3333_4444;
    busy = 1'b1;
    repeat (3) cycle();
    busy = 1'b0;
    cycle();
    cycle();

    // starvation: slot busy for 20 cycles
    do_reset();
    vld[2] = 1'b1; preg[2] = 7'h7F; data[2] = 64'hFFFF_0000_ABCD_0123;
    busy = 1'b1;
    repeat (20) cycle();
    busy = 1'b0;
    cycle();
    cycle();
    cycle();

    // reset in the cycle right after a grant
    do_reset();
    vld[1] = 1'b1; preg[1] = 7'h33; data[1] = 64'h5555;
    cycle();
    vld[0] = 1'b1; preg[0] = 7'h44; data[0] = 64'h6666;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    clear_reqs();
    cycle();
    cycle();

    // randomized traffic with busy bursts and occasional resets
    do_reset();
    burst = 0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom % 400 == 0);
      if (burst > 0) begin
        busy = 1'b1;
        burst--;
      end else if ($urandom % 60 == 0) begin
        burst = $urandom_range(14, 5);
        busy  = 1'b1;
      end else begin
        busy = ($urandom % 3 == 0);
      end
      for (int i = 0; i < N; i++) begin
        if (!vld[i] && ($urandom % 2 == 0)) begin
          vld[i]  = 1'b1;
          preg[i] = 7'($urandom);
          data[i] = {$urandom, $urandom};
        end
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
